// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: load/store funct3, memory modes, LSU states.
// Also a helper mapping the funct3 size field to a byte count.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MODE_B = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_W = 2'b10;

  function automatic logic [2:0] lsu_size(
    input logic [1:0] sz
  );
    logic [2:0] n;
    n = 3'd4;
    unique case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extension: funct3 + raw assembled word -> extended word.
// Ports: funct3 (in, 3), raw (in, 32), ext (out, 32).
module lsu_load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = 32'h0;
    unique case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ext = raw;
      F3_BU:   ext = {24'h0, raw[7:0]};
      F3_HU:   ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: IDLE -> ACCESS (N byte cycles) -> RESP.
// Ports: req_* from execute, rsp_* strobe back, mem_* to byte memory.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_mode_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  cnt_q;

  logic        accept;
  logic        f3_bad;
  logic        range_bad;
  logic        req_err;
  logic        last;
  logic [2:0]  req_size;
  logic [2:0]  cur_size;
  logic [32:0] end_addr;
  logic [31:0] ext_data;
  logic [23:0] unused_rdata;

  assign unused_rdata = mem_rdata_i[31:8];

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;

  assign req_size = lsu_size(req_funct3_i[1:0]);
  assign cur_size = lsu_size(f3_q[1:0]);

  // 33-bit sum so a request wrapping past 2^32 is out of range.
  assign end_addr  = {1'b0, req_addr_i} + {30'd0, req_size};
  assign range_bad = end_addr > 33'(MEM_BYTES);

  always_comb begin
    f3_bad = 1'b1;
    unique case (req_funct3_i)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = req_we_i;
      default:          f3_bad = 1'b1;
    endcase
  end

  assign req_err = f3_bad || range_bad;
  assign last    = ({1'b0, cnt_q} == (cur_size - 3'd1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept)
          state_d = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS:
        if (last)
          state_d = ST_RESP;
      ST_RESP:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
        rdata_q <= 32'h0;
        cnt_q   <= 2'd0;
      end else if (state_q == ST_ACCESS) begin
        cnt_q <= cnt_q + 2'd1;
        if (!we_q)
          rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i[7:0];
      end
    end
  end

  lsu_load_extend u_ext (
    .funct3 (f3_q),
    .raw    (rdata_q),
    .ext    (ext_data)
  );

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_mode_o  = 2'b00;
    mem_wdata_o = 32'h0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = 32'h0;
    unique case (1'b1)
      (state_q == ST_ACCESS): begin
        mem_we_o    = we_q;
        mem_addr_o  = addr_q + {30'd0, cnt_q};
        mem_mode_o  = MODE_B;
        mem_wdata_o = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
      end
      (state_q == ST_RESP): begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q || err_q) ? 32'h0 : ext_data;
      end
      default: ;
    endcase
  end

endmodule
